// File: rtl/pmu_cmd_seq.sv
// Clock-change command sequencer: validates 8-bit host commands, runs hold/quiesce/apply/release
// per domain, and owns the single sleep timer that parks a domain and restores it on expiry.
module pmu_cmd_seq #(
  parameter int unsigned TICKS_PER_SEC  = 12000000,
  parameter int unsigned QUIESCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       wake,
  output logic [2:0] hold,
  output logic [5:0] src_sel,
  output logic [8:0] fr_sel,
  output logic [2:0] sleeping
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_QUIESCE, S_APPLY} state_t;
  typedef enum logic [1:0] {OP_CFG, OP_SLEEP, OP_WAKE} op_t;

  state_t      state, state_d;
  op_t         op;
  logic [7:0]  cmd_q;
  logic        wake_op;
  logic [1:0]  tgt, new_src, sleep_dom, saved_src;
  logic [2:0]  new_fr, saved_fr;
  logic [3:0]  q_cnt, sec_cnt;
  logic [23:0] tick_cnt;
  logic        timer_on, pending, pend_d;

  logic [1:0]  dec_dom, seq_dom, cur_src;
  logic [2:0]  dec_fr, cur_fr;
  logic        dec_sleep, dec_err, dec_cancel, tgt_sleeping, dom_sleeping, kill, expire;

  always_comb begin
    dec_dom      = cmd_q[7:6];
    dec_sleep    = (dec_dom == 2'b11);
    cur_src      = '0;
    cur_fr       = '0;
    tgt_sleeping = 1'b0;
    dom_sleeping = 1'b0;
    for (int unsigned d = 0; d < 3; d++) begin
      if (cmd_q[5:4] == 2'(d)) begin
        cur_src      = src_sel[2*d +: 2];
        cur_fr       = fr_sel[3*d +: 3];
        tgt_sleeping = sleeping[d];
      end
      if (dec_dom == 2'(d)) dom_sleeping = sleeping[d];
    end
    case (cmd_q[3:2])
      2'b01:   dec_fr = 3'b001;
      2'b10:   dec_fr = 3'b010;
      2'b11:   dec_fr = 3'b100;
      default: dec_fr = 3'b000;
    endcase
    if (dec_sleep)
      dec_err = (cmd_q[5:4] == 2'b11) || ((cmd_q[3:0] != 4'd0) && (|sleeping));
    else
      dec_err = (cmd_q[5:4] == 2'b11) || (cmd_q[3:2] == 2'b00);
    dec_cancel = dec_sleep && (cmd_q[3:0] == 4'd0) && !dec_err;
    seq_dom    = wake_op ? sleep_dom : (dec_sleep ? cmd_q[5:4] : dec_dom);

    // Any host action that ends a sleep also drops a wake already raised for it.
    kill   = (state == S_DECODE) && !wake_op && !dec_err &&
             ((dec_cancel && tgt_sleeping) || (!dec_sleep && dom_sleeping));
    expire = timer_on && (tick_cnt == 24'(TICKS_PER_SEC - 1)) && (sec_cnt == 4'd1);
    if (kill)
      pend_d = 1'b0;
    else if ((state == S_IDLE) && pending)
      pend_d = 1'b0;
    else
      pend_d = pending | expire;

    state_d = state;
    case (state)
      S_IDLE:    if (pending || (cmd_valid && cmd_ready)) state_d = S_DECODE;
      S_DECODE:  state_d = (!wake_op && (dec_err || dec_cancel)) ? S_IDLE : S_QUIESCE;
      S_QUIESCE: if (q_cnt == 4'd0) state_d = S_APPLY;
      S_APPLY:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      wake      <= 1'b0;
      hold      <= '0;
      src_sel   <= 6'b00_10_01;
      fr_sel    <= 9'b001_100_010;
      sleeping  <= '0;
      op        <= OP_CFG;
      cmd_q     <= '0;
      wake_op   <= 1'b0;
      tgt       <= '0;
      new_src   <= '0;
      new_fr    <= '0;
      q_cnt     <= '0;
      sleep_dom <= '0;
      saved_src <= '0;
      saved_fr  <= '0;
      timer_on  <= 1'b0;
      sec_cnt   <= '0;
      tick_cnt  <= '0;
      pending   <= 1'b0;
    end else begin
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      wake      <= 1'b0;
      cmd_ready <= (state_d == S_IDLE) && !pend_d;
      pending   <= pend_d;

      if (timer_on) begin
        if (tick_cnt == 24'(TICKS_PER_SEC - 1)) begin
          tick_cnt <= '0;
          sec_cnt  <= sec_cnt - 4'd1;
          if (sec_cnt == 4'd1) timer_on <= 1'b0;
        end else begin
          tick_cnt <= tick_cnt + 24'd1;
        end
      end
      if (kill) timer_on <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pending) begin
            wake_op <= 1'b1;
          end else if (cmd_valid && cmd_ready) begin
            cmd_q   <= cmd_data;
            wake_op <= 1'b0;
          end
        end
        S_DECODE: begin
          if (wake_op || !(dec_err || dec_cancel)) begin
            tgt   <= seq_dom;
            q_cnt <= 4'(QUIESCE_CYCLES - 1);
            for (int unsigned d = 0; d < 3; d++)
              if (seq_dom == 2'(d)) hold[d] <= 1'b1;
          end
          if (wake_op) begin
            new_src <= saved_src;
            new_fr  <= saved_fr;
            op      <= OP_WAKE;
          end else if (dec_err) begin
            cmd_err <= 1'b1;
          end else if (dec_cancel) begin
            cmd_done <= 1'b1;
            for (int unsigned d = 0; d < 3; d++)
              if (cmd_q[5:4] == 2'(d)) sleeping[d] <= 1'b0;
          end else if (dec_sleep) begin
            saved_src <= cur_src;
            saved_fr  <= cur_fr;
            sleep_dom <= cmd_q[5:4];
            new_src   <= 2'b00;
            new_fr    <= 3'b001;
            op        <= OP_SLEEP;
          end else begin
            new_src <= cmd_q[5:4];
            new_fr  <= dec_fr;
            op      <= OP_CFG;
            for (int unsigned d = 0; d < 3; d++)
              if (dec_dom == 2'(d)) sleeping[d] <= 1'b0;
          end
        end
        S_QUIESCE: begin
          if (q_cnt != 4'd0) q_cnt <= q_cnt - 4'd1;
        end
        S_APPLY: begin
          hold <= '0;
          for (int unsigned d = 0; d < 3; d++) begin
            if (tgt == 2'(d)) begin
              src_sel[2*d +: 2] <= new_src;
              fr_sel[3*d +: 3]  <= new_fr;
              sleeping[d]       <= (op == OP_SLEEP);
            end
          end
          case (op)
            OP_SLEEP: begin
              cmd_done <= 1'b1;
              timer_on <= 1'b1;
              sec_cnt  <= cmd_q[3:0];
              tick_cnt <= '0;
            end
            OP_WAKE: wake     <= 1'b1;
            default: cmd_done <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_cmd_seq.sv
// Scoreboard bench for pmu_cmd_seq: a reference model predicts each done/err/wake pulse,
// its cycle and the resulting select/sleep state; the monitor pops and compares on each pulse.
module tb_pmu_cmd_seq;
  localparam int unsigned TPS = 10;
  localparam int unsigned QC  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, cmd_done, cmd_err, wake;
  logic [2:0] hold, sleeping;
  logic [5:0] src_sel;
  logic [8:0] fr_sel;

  pmu_cmd_seq #(.TICKS_PER_SEC(TPS), .QUIESCE_CYCLES(QC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_err(cmd_err), .wake(wake),
    .hold(hold), .src_sel(src_sel), .fr_sel(fr_sel), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [2:0]  kind;
    int unsigned cyc;
    logic [5:0]  src;
    logic [8:0]  fr;
    logic [2:0]  slp;
  } exp_t;

  localparam logic [2:0] K_DONE = 3'b100;
  localparam logic [2:0] K_ERR  = 3'b010;
  localparam logic [2:0] K_WAKE = 3'b001;

  exp_t sb[$];
  exp_t mon_e;

  logic [5:0]  m_src;
  logic [8:0]  m_fr;
  logic [2:0]  m_slp;
  logic [1:0]  m_sv_src;
  logic [2:0]  m_sv_fr;
  int unsigned m_wdom, m_wcyc;

  task automatic model_reset();
    m_src = 6'b001001;
    m_fr  = 9'b001100010;
    m_slp = 3'b000;
  endtask

  task automatic push(input logic [2:0] k, input int unsigned c);
    exp_t e;
    e.kind = k; e.cyc = c; e.src = m_src; e.fr = m_fr; e.slp = m_slp;
    sb.push_back(e);
  endtask

  function automatic logic [2:0] fr_hot(input logic [1:0] code);
    case (code)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic send_cmd(input logic [7:0] b, output int unsigned acc);
    int unsigned dom, tgt, n;
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      tick();
    end
    check_eq("accept_wait", 32'(ok), 32'd1);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
    dom = 32'(b[7:6]);
    tgt = 32'(b[5:4]);
    n   = 32'(b[3:0]);
    if (dom != 3) begin
      if (b[5:4] == 2'b11 || b[3:2] == 2'b00) push(K_ERR, acc + 2);
      else begin
        m_src[2*dom +: 2] = b[5:4];
        m_fr[3*dom +: 3]  = fr_hot(b[3:2]);
        m_slp[dom]        = 1'b0;
        push(K_DONE, acc + 7);
      end
    end else if (tgt == 3 || (n != 0 && m_slp != 3'b000)) begin
      push(K_ERR, acc + 2);
    end else if (n == 0) begin
      m_slp[tgt] = 1'b0;
      push(K_DONE, acc + 2);
    end else begin
      m_sv_src = m_src[2*tgt +: 2];
      m_sv_fr  = m_fr[3*tgt +: 3];
      m_src[2*tgt +: 2] = 2'b00;
      m_fr[3*tgt +: 3]  = 3'b001;
      m_slp[tgt] = 1'b1;
      m_wdom = tgt;
      m_wcyc = acc + 14 + n * TPS;
      push(K_DONE, acc + 7);
    end
  endtask

  task automatic expect_wake();
    m_src[2*m_wdom +: 2] = m_sv_src;
    m_fr[3*m_wdom +: 3]  = m_sv_fr;
    m_slp[m_wdom] = 1'b0;
    push(K_WAKE, m_wcyc);
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (cmd_done || cmd_err || wake) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'({cmd_done, cmd_err, wake}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("pulse_kind",  32'({cmd_done, cmd_err, wake}), 32'(mon_e.kind));
        check_eq("pulse_cycle", cyc, mon_e.cyc);
        check_eq("src_sel",     32'(src_sel), 32'(mon_e.src));
        check_eq("fr_sel",      32'(fr_sel), 32'(mon_e.fr));
        check_eq("sleeping",    32'(sleeping), 32'(mon_e.slp));
        check_eq("hold_idle",   32'(hold), 32'd0);
        check_eq("ready_after", 32'(cmd_ready), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned a, a2;
    model_reset();
    repeat (3) @(posedge clk);
    tick();
    reset = 1'b0;
    check_eq("rst_src",   32'(src_sel), 32'h09);
    check_eq("rst_fr",    32'(fr_sel), 32'h062);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_hold",  32'(hold), 32'd0);
    check_eq("rst_sleep", 32'(sleeping), 32'd0);
    check_eq("rst_pulse", 32'({cmd_done, cmd_err, wake}), 32'd0);

    // Config d0 with hold window check
    send_cmd(8'h18, a);
    for (int unsigned k = 1; k <= 7; k++) begin
      check_eq($sformatf("hold_c%0d", k), 32'(hold), (k >= 2 && k <= 6) ? 32'd1 : 32'd0);
      if (k <= 2) check_eq($sformatf("ready_c%0d", k), 32'(cmd_ready), 32'd0);
      tick();
    end
    drain(20);

    send_cmd(8'h6C, a); drain(20);
    send_cmd(8'h30, a); drain(20);
    send_cmd(8'h10, a); drain(20);
    send_cmd(8'hF1, a); drain(20);
    send_cmd(8'hC0, a); drain(20);

    // Timed sleep on d2
    send_cmd(8'hE2, a);
    expect_wake();
    drain(80);
    check_eq("d2_awake", 32'(sleeping), 32'd0);

    // Wake request takes priority over a waiting host command
    send_cmd(8'hC1, a);
    drain(20);
    wait_until(a + 17);
    check_eq("ready_pending", 32'(cmd_ready), 32'd0);
    expect_wake();
    send_cmd(8'h5C, a2);
    check_eq("accept_after_wake", a2, a + 24);
    drain(40);

    // Host config cancels sleep on d1; second-domain sleep rejected meanwhile
    send_cmd(8'hD2, a);
    send_cmd(8'hC2, a2);
    send_cmd(8'h58, a2);
    drain(40);
    check_eq("d1_cancelled", 32'(sleeping), 32'd0);
    wait_until(a + 50);

    // Explicit cancel keeps parked config
    send_cmd(8'hC3, a);
    send_cmd(8'hC0, a2);
    drain(40);
    check_eq("d0_cancelled", 32'(sleeping), 32'd0);
    wait_until(a + 60);

    // Reset in the middle of a sequence
    cmd_valid = 1'b1;
    cmd_data  = 8'h2C;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    a = cyc;
    tick();
    cmd_valid = 1'b0;
    wait_until(a + 4);
    check_eq("hold_before_reset", 32'(hold), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_src",   32'(src_sel), 32'h09);
    check_eq("mid_rst_fr",    32'(fr_sel), 32'h062);
    check_eq("mid_rst_hold",  32'(hold), 32'd0);
    check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid_rst_pulse", 32'({cmd_done, cmd_err, wake}), 32'd0);
    reset = 1'b0;
    model_reset();
    sb.delete();
    repeat (10) tick();

    send_cmd(8'h18, a);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
